// File: rtl/pipeline_debug_ctrl.sv
// Run-control and snapshot engine for the pipelined MIPS core: free-run, N-cycle step,
// PC breakpoint, halt, and a byte-serial dump of register/memory/PC words over UART.
module pipeline_debug_ctrl #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_MEM  = 5,
  parameter int STEP_W   = 16,
  localparam int SEL_W   = $clog2(NUM_REGS + NUM_MEM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic [DATA_W-1:0] pc,
  output logic [SEL_W-1:0]  snap_sel,
  input  logic [DATA_W-1:0] snap_data,
  output logic              enable,
  output logic              enable_pc,
  output logic              halted
);
  localparam int DB  = DATA_W / 8;
  localparam int SB  = STEP_W / 8;
  localparam int AB  = (DB > SB) ? DB : SB;
  localparam int AW  = AB * 8;
  localparam int ACW = $clog2(AB + 1);
  localparam int BCW = $clog2(DB + 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_REGS + NUM_MEM);

  localparam logic [7:0] CMD_C = 8'h63;
  localparam logic [7:0] CMD_S = 8'h73;
  localparam logic [7:0] CMD_B = 8'h62;
  localparam logic [7:0] CMD_X = 8'h78;
  localparam logic [7:0] CMD_D = 8'h64;
  localparam logic [7:0] CMD_H = 8'h68;

  typedef enum logic [2:0] {S_IDLE, S_ARG, S_RUN, S_STEP, S_DUMP} state_t;
  state_t state, state_next;

  logic              arg_is_step;
  logic [ACW-1:0]    arg_cnt;
  logic [AW-1:0]     arg_shift;
  logic [AW-1:0]     arg_val;
  logic              bp_valid;
  logic [DATA_W-1:0] bp_addr;
  logic [STEP_W-1:0] step_cnt;
  logic              first;
  logic              load;
  logic [BCW-1:0]    byte_cnt;
  logic [DATA_W-1:0] shift;

  logic rx_halt, arg_last, arg_done, bp_hit, xfer, byte_last, sel_last, run_en;

  assign rx_halt   = rx_valid && (rx_data == CMD_H);
  assign arg_val   = AW'({arg_shift, rx_data});
  assign arg_last  = arg_cnt == (arg_is_step ? ACW'(SB - 1) : ACW'(DB - 1));
  assign arg_done  = rx_valid && arg_last;
  // first masks the match on the first RUN cycle so 'c' from a breakpoint PC advances
  assign bp_hit    = bp_valid && (pc == bp_addr) && !first;
  assign xfer      = tx_valid && tx_ready;
  assign byte_last = byte_cnt == BCW'(DB - 1);
  assign sel_last  = snap_sel == SEL_LAST;
  assign tx_data   = shift[DATA_W-1 -: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (rx_valid) begin
        case (rx_data)
          CMD_C:        state_next = S_RUN;
          CMD_S, CMD_B: state_next = S_ARG;
          CMD_D:        state_next = S_DUMP;
          default:      state_next = S_IDLE;
        endcase
      end
      S_ARG: if (arg_done) begin
        if (arg_is_step && (arg_val[STEP_W-1:0] != '0)) state_next = S_STEP;
        else                                            state_next = S_IDLE;
      end
      S_RUN:   if (rx_halt || bp_hit) state_next = S_IDLE;
      S_STEP:  if (rx_halt || (step_cnt == STEP_W'(1))) state_next = S_IDLE;
      S_DUMP:  if (xfer && byte_last && sel_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    run_en = 1'b0;
    halted = 1'b0;
    case (state)
      S_IDLE:  halted = 1'b1;
      S_RUN:   run_en = !bp_hit;
      S_STEP:  run_en = 1'b1;
      default: run_en = 1'b0;
    endcase
    enable    = run_en;
    enable_pc = run_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arg_is_step <= 1'b0;
      arg_cnt     <= '0;
      arg_shift   <= '0;
      bp_valid    <= 1'b0;
      bp_addr     <= '0;
      step_cnt    <= '0;
      first       <= 1'b1;
      load        <= 1'b0;
      byte_cnt    <= '0;
      shift       <= '0;
      tx_valid    <= 1'b0;
      snap_sel    <= '0;
    end else begin
      first <= (state != S_RUN);
      case (state)
        S_IDLE: if (rx_valid) begin
          if (rx_data == CMD_S || rx_data == CMD_B) begin
            arg_is_step <= (rx_data == CMD_S);
            arg_cnt     <= '0;
            arg_shift   <= '0;
          end
          if (rx_data == CMD_X) bp_valid <= 1'b0;
          if (rx_data == CMD_D) begin
            load     <= 1'b1;
            snap_sel <= '0;
            byte_cnt <= '0;
          end
        end
        S_ARG: if (rx_valid) begin
          arg_shift <= arg_val;
          arg_cnt   <= arg_cnt + 1'b1;
          if (arg_last) begin
            if (arg_is_step) begin
              step_cnt <= arg_val[STEP_W-1:0];
            end else begin
              bp_addr  <= arg_val[DATA_W-1:0];
              bp_valid <= 1'b1;
            end
          end
        end
        S_STEP: step_cnt <= rx_halt ? '0 : step_cnt - 1'b1;
        S_DUMP: begin
          // load cycle: snap_sel has been stable for a full cycle before capture
          if (load) begin
            shift    <= snap_data;
            tx_valid <= 1'b1;
            byte_cnt <= '0;
            load     <= 1'b0;
          end else if (xfer) begin
            if (byte_last) begin
              tx_valid <= 1'b0;
              if (sel_last) begin
                snap_sel <= '0;
              end else begin
                snap_sel <= snap_sel + 1'b1;
                load     <= 1'b1;
              end
            end else begin
              shift    <= shift << 8;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: table of step/ignore vectors plus hand
// sequences for breakpoint, halt, dump handshake and mid-dump reset.
module tb_pipeline_debug_ctrl;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_MEM = 5;
  localparam int STEP_W = 16;
  localparam int SEL_W = $clog2(NUM_REGS + NUM_MEM + 1);
  localparam int DUMP_BYTES = (NUM_REGS + NUM_MEM + 1) * (DATA_W / 8);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_ready = 1'b0;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic [DATA_W-1:0] pc;
  logic [SEL_W-1:0]  snap_sel;
  logic [DATA_W-1:0] snap_data;
  logic              enable, enable_pc, halted;
  logic              pc_clr = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  pipeline_debug_ctrl #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_MEM(NUM_MEM), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .pc(pc),
    .snap_sel(snap_sel), .snap_data(snap_data), .enable(enable),
    .enable_pc(enable_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Stand-ins for the core: word k reads as k replicated in every byte; PC advances 4 per enabled cycle
  assign snap_data = {4{{2'b00, snap_sel}}};
  always_ff @(posedge clk) begin
    if (pc_clr)         pc <= '0;
    else if (enable_pc) pc <= pc + 32'd4;
  end

  typedef struct {
    logic [23:0] bytes;
    int          nb;
    int          exp_en;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; the byte is taken at the next edge
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic clear_pc();
    pc_clr = 1'b1;
    @(posedge clk); #1;
    pc_clr = 1'b0;
  endtask

  task automatic send_bp(input logic [31:0] a);
    send(8'h62);
    for (int j = 0; j < 4; j++) send(a[31-8*j -: 8]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc0, stop_pc;
    logic        stop_halted, stall_prev, fast_ok;
    logic [7:0]  prev_data;
    int          en_cnt, k, diff, nbytes, en_seen, cyc;

    vecs[0] = '{bytes: {8'h73, 8'h00, 8'h03}, nb: 3, exp_en: 3};
    vecs[1] = '{bytes: {8'h73, 8'h00, 8'h00}, nb: 3, exp_en: 0};
    vecs[2] = '{bytes: {8'h73, 8'h00, 8'h01}, nb: 3, exp_en: 1};
    vecs[3] = '{bytes: {8'h73, 8'h00, 8'h63}, nb: 3, exp_en: 99};
    vecs[4] = '{bytes: {8'h78, 8'h00, 8'h00}, nb: 1, exp_en: 0};
    vecs[5] = '{bytes: {8'h7a, 8'h00, 8'h00}, nb: 1, exp_en: 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset enable", enable, 0);
    check("reset enable_pc", enable_pc, 0);
    check("reset tx_valid", tx_valid, 0);
    check("reset tx_data", tx_data, 0);
    check("reset snap_sel", snap_sel, 0);
    check("reset halted", halted, 1);
    rst_n  = 1'b1;
    pc_clr = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      pc0 = pc;
      for (int j = 0; j < vecs[i].nb; j++) send(vecs[i].bytes[23-8*j -: 8]);
      en_cnt = 0; k = 0; diff = 0;
      for (int c = 1; c <= 400; c++) begin
        @(negedge clk);
        if (enable !== enable_pc) diff++;
        if (halted === 1'b1) begin
          k = c;
          break;
        end
        if (enable === 1'b1) en_cnt++;
      end
      @(posedge clk); #1;
      check($sformatf("vec%0d enable cycles", i), en_cnt, vecs[i].exp_en);
      check($sformatf("vec%0d halted cycle", i), k, vecs[i].exp_en + 1);
      check($sformatf("vec%0d pc advance", i), pc - pc0, 4 * vecs[i].exp_en);
      check($sformatf("vec%0d enable_pc equal", i), diff, 0);
      $display("vec%0d: %0d bytes, %0d enable cycles", i, vecs[i].nb, en_cnt);
    end

    // Breakpoint at 0x10, run from 0
    send_bp(32'h10);
    clear_pc();
    send(8'h63);
    en_cnt = 0; stop_pc = '1; stop_halted = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (enable !== 1'b1) begin
        stop_pc = pc;
        stop_halted = halted;
        break;
      end
      en_cnt++;
    end
    check("bp enable cycles", en_cnt, 4);
    check("bp stop pc", stop_pc, 32'h10);
    check("bp halted in match cycle", stop_halted, 0);
    @(negedge clk);
    check("bp halted after match", halted, 1);
    check("bp pc frozen", pc, 32'h10);
    @(posedge clk); #1;
    $display("breakpoint: stopped at pc=0x%0h after %0d cycles", stop_pc, en_cnt);

    // Continue from the breakpoint PC, then halt 5 cycles later
    send(8'h63);
    @(negedge clk);
    check("resume first enable", enable, 1);
    check("resume first pc", pc, 32'h10);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    check("enable before h", enable, 1);
    send(8'h68);
    @(negedge clk);
    check("enable after h", enable, 0);
    check("halted after h", halted, 1);
    repeat (3) @(posedge clk);
    #1;
    check("pc after h", pc, 32'h28);
    $display("resume+halt: pc=0x%0h", pc);

    // Clear breakpoint, run past 0x10
    send(8'h78);
    clear_pc();
    send(8'h63);
    repeat (10) @(posedge clk);
    #1;
    send(8'h68);
    @(posedge clk); #1;
    check("no bp pc", pc, 32'h2c);
    check("no bp halted", halted, 1);
    $display("bp cleared: pc=0x%0h", pc);

    // Dump with tx_ready toggling; 'c','z' arrive mid-dump
    pc0 = pc;
    send(8'h64);
    nbytes = 0; stall_prev = 1'b0; prev_data = 8'h00; en_seen = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      tx_ready = (c % 2 == 1);
      if (c == 20) begin
        rx_valid = 1'b1; rx_data = 8'h63;
      end else if (c == 21) begin
        rx_data = 8'h7a;
      end else begin
        rx_valid = 1'b0;
      end
      if (c == 2) check("dump first valid", tx_valid, 1);
      if (enable !== 1'b0) en_seen++;
      if (stall_prev) begin
        check("dump stall valid", tx_valid, 1);
        check("dump stall data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        check($sformatf("dump byte %0d", nbytes), tx_data, nbytes / 4);
        nbytes++;
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (nbytes == DUMP_BYTES && halted === 1'b1) break;
    end
    check("dump byte count", nbytes, DUMP_BYTES);
    check("dump halted", halted, 1);
    check("dump snap_sel", snap_sel, 0);
    check("dump tx_valid", tx_valid, 0);
    check("dump enable seen", en_seen, 0);
    check("dump pc frozen", pc, pc0);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    $display("dump (toggling ready): %0d bytes", nbytes);

    // Dump with tx_ready held high: throughput bound
    tx_ready = 1'b1;
    send(8'h64);
    nbytes = 0; cyc = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) nbytes++;
      if (nbytes == DUMP_BYTES && halted === 1'b1) begin
        cyc = c;
        break;
      end
    end
    fast_ok = (cyc >= 1) && (cyc <= DUMP_BYTES + 2 * 38 + 1);
    check("dump2 byte count", nbytes, DUMP_BYTES);
    check("dump2 cycle bound", fast_ok, 1);
    @(posedge clk); #1;
    $display("dump (ready high): %0d bytes, idle after %0d cycles", nbytes, cyc);

    // Reset in the middle of a dump with a breakpoint armed
    send_bp(32'h10);
    send(8'h64);
    nbytes = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) nbytes++;
      if (nbytes == 41) break;
    end
    @(posedge clk); #2;
    check("pre-reset tx_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid-dump reset tx_valid", tx_valid, 0);
    check("mid-dump reset snap_sel", snap_sel, 0);
    check("mid-dump reset halted", halted, 1);
    check("mid-dump reset enable", enable, 0);
    check("mid-dump reset tx_data", tx_data, 0);
    #1;
    rst_n = 1'b1;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    clear_pc();
    send(8'h63);
    repeat (8) @(posedge clk);
    #1;
    send(8'h68);
    @(posedge clk); #1;
    check("bp cleared by reset pc", pc, 32'h24);
    $display("mid-dump reset: run after reset reached pc=0x%0h", pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
